egress_fsm: RTL

- Egress-side counterpart of the ingress front end.
- Reads store-and-forward frames out of one per-port frame buffer (FWFT FIFO read side) and transmits them on the port's egress AXI-stream.
- Starts a frame only once it is fully committed by the write side. Frames dropped during write are never committed and are never seen here.
- Enforces a minimum inter-frame gap and a maximum frame length (truncate + discard).

---
 rtl/egress_fsm_pkg.sv | 29 ++
 rtl/egress_fsm_if.sv | 36 +++
 rtl/egress_fsm_skid_buffer.sv | 53 +++++
 rtl/egress_fsm.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/egress_fsm_pkg.sv
// Shared types and defaults for the egress frame path: AXI-stream structs,
// egress FSM states and default frame limits.
`timescale 1ns/1ps
package egress_fsm_pkg;

  localparam int DEF_FRAME_CNT_W   = 6;
  localparam int DEF_MAX_FRAME_LEN = 1518;
  localparam int DEF_IFG_CYCLES    = 12;
  localparam int DEF_LEN_W         = 11;
  localparam int SKID_WORD_W       = 9;

  typedef struct packed {
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
  } axis_source_t;

  typedef struct packed {
    logic tready;
  } axis_sink_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    DISCARD   = 2'd2,
    WAIT_DONE = 2'd3
  } egress_state_e;

endpackage

// File: rtl/egress_fsm_if.sv
// Bundle between the egress FSM, the FWFT frame-buffer read side and the
// egress AXI-stream port.
`timescale 1ns/1ps
interface egress_fsm_if;
  import egress_fsm_pkg::*;

  // Handshakes: an AXIS beat transfers on a cycle with tvalid & tready, and the
  // source holds tdata/tlast and keeps tvalid high until it does. The buffer
  // read pops the FWFT head on a cycle with rd_en, which is only raised while
  // rd_empty is low.
  logic [7:0]   rd_data;
  logic         rd_last;
  logic         rd_empty;
  logic         rd_en;
  axis_source_t egress_source;
  axis_sink_t   egress_sink;

  modport master (
    input  rd_data,
    input  rd_last,
    input  rd_empty,
    input  egress_sink,
    output rd_en,
    output egress_source
  );

  modport slave (
    output rd_data,
    output rd_last,
    output rd_empty,
    output egress_sink,
    input  rd_en,
    input  egress_source
  );

endinterface

// File: rtl/egress_fsm_skid_buffer.sv
// Two-entry registered-output skid buffer carrying {tlast, tdata} onto an
// AXI-stream source; reusable by any egress path.
`timescale 1ns/1ps
module egress_skid_buffer
  import egress_fsm_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [SKID_WORD_W-1:0] i_in_word,
  output axis_source_t           o_axis,
  input  axis_sink_t             i_axis
);

  logic                   r_out_valid;
  logic [SKID_WORD_W-1:0] r_out_word;
  logic                   r_skid_valid;
  logic [SKID_WORD_W-1:0] r_skid_word;
  logic                   w_out_free;

  assign w_out_free = !r_out_valid || i_axis.tready;
  // Ready depends only on a register, so the upstream pop never sees tready.
  assign o_in_ready = !r_skid_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_word   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_word  <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_word   <= r_skid_word;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= i_in_valid;
        if (i_in_valid) begin
          r_out_word <= i_in_word;
        end
      end
    end else if (i_in_valid && !r_skid_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_word  <= i_in_word;
    end
  end

  assign o_axis.tvalid = r_out_valid;
  assign o_axis.tdata  = r_out_word[7:0];
  assign o_axis.tlast  = r_out_word[8];

endmodule

// File: rtl/egress_fsm.sv
// Egress frame engine: starts committed store-and-forward frames from the
// per-port buffer, truncates over-long frames, and spaces frames by an IFG.
`timescale 1ns/1ps
module egress_fsm
  import egress_fsm_pkg::*;
#(
  parameter int FRAME_CNT_W   = DEF_FRAME_CNT_W,
  parameter int MAX_FRAME_LEN = DEF_MAX_FRAME_LEN,
  parameter int IFG_CYCLES    = DEF_IFG_CYCLES,
  parameter int LEN_W         = DEF_LEN_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_frame_committed,
  egress_fsm_if.master           io_bus,
  output logic                   o_frame_done,
  output logic                   o_frame_truncated,
  output logic [FRAME_CNT_W-1:0] o_pending_frames,
  output egress_state_e          o_state
);

  localparam int IFG_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

  egress_state_e          r_state;
  egress_state_e          w_next_state;
  logic [FRAME_CNT_W-1:0] r_pending;
  logic [LEN_W-1:0]       r_byte_cnt;
  logic [IFG_W-1:0]       r_ifg_cnt;
  logic                   r_truncated;
  logic                   r_last_sent;

  logic                   w_start;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_done;
  logic                   w_leave;
  logic                   w_forced_last;
  logic                   w_last_hs;
  logic                   w_skid_ready;
  logic                   w_set_trunc;
  logic [SKID_WORD_W-1:0] w_push_word;
  axis_source_t           w_axis;

  assign w_start       = (r_state == IDLE) && (r_pending != '0) && (r_ifg_cnt == '0);
  assign w_forced_last = (r_byte_cnt == LEN_W'(MAX_FRAME_LEN - 1));
  assign w_last_hs     = w_axis.tvalid && io_bus.egress_sink.tready && w_axis.tlast;
  assign w_push_word   = {io_bus.rd_last | w_forced_last, io_bus.rd_data};
  assign w_leave       = (r_state != IDLE) && (w_next_state == IDLE);

  // The IDLE->STREAM cycle already pops, so IDLE and STREAM share the pop path.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_push       = 1'b0;
    w_done       = 1'b0;
    w_set_trunc  = 1'b0;
    case (r_state)
      IDLE, STREAM: begin
        if (w_start || (r_state == STREAM)) begin
          w_pop        = !io_bus.rd_empty && w_skid_ready;
          w_push       = w_pop;
          w_next_state = STREAM;
          if (w_pop && io_bus.rd_last) begin
            w_next_state = WAIT_DONE;
          end else if (w_pop && w_forced_last) begin
            w_next_state = DISCARD;
            w_set_trunc  = 1'b1;
          end
        end
      end
      DISCARD: begin
        // The cut frame's tlast can drain while the tail is still being dropped.
        w_pop  = !io_bus.rd_empty;
        w_done = w_last_hs;
        if (w_pop && io_bus.rd_last) begin
          w_next_state = (w_last_hs || r_last_sent) ? IDLE : WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        w_done = w_last_hs;
        if (w_last_hs) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_byte_cnt  <= '0;
      r_ifg_cnt   <= '0;
      r_truncated <= 1'b0;
      r_last_sent <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (i_frame_committed && !w_start) begin
        r_pending <= r_pending + FRAME_CNT_W'(1);
      end else if (!i_frame_committed && w_start) begin
        r_pending <= r_pending - FRAME_CNT_W'(1);
      end

      if (w_leave) begin
        r_byte_cnt <= '0;
      end else if (w_push) begin
        r_byte_cnt <= r_byte_cnt + LEN_W'(1);
      end

      if (w_leave) begin
        r_ifg_cnt <= IFG_W'(IFG_CYCLES);
      end else if (r_ifg_cnt != '0) begin
        r_ifg_cnt <= r_ifg_cnt - IFG_W'(1);
      end

      if (w_leave) begin
        r_truncated <= 1'b0;
        r_last_sent <= 1'b0;
      end else begin
        if (w_set_trunc) begin
          r_truncated <= 1'b1;
        end
        if ((r_state == DISCARD) && w_last_hs) begin
          r_last_sent <= 1'b1;
        end
      end
    end
  end

  pending_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(i_frame_committed && !w_start && (&r_pending)));

  egress_skid_buffer u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_valid (w_push),
    .o_in_ready (w_skid_ready),
    .i_in_word  (w_push_word),
    .o_axis     (w_axis),
    .i_axis     (io_bus.egress_sink)
  );

  assign io_bus.egress_source = w_axis;
  assign io_bus.rd_en         = w_pop;
  assign o_frame_done         = w_done;
  assign o_frame_truncated    = w_done && r_truncated;
  assign o_pending_frames     = r_pending;
  assign o_state              = r_state;

endmodule
